batch_scheduler: RTL and testbench

- Sequences the shared sample RAM for the batch control-bounded filter.
- Input words are written into a triple-buffered RAM; each section holds one batch of `depth` words.
- Each cycle the block issues three accesses:
  - a write address for the incoming sample;
  - a reverse-order read address for the backward recursion over the previous batch;
  - a forward-order read address for the forward recursion over the batch before that.
- Also produces the batch-boundary strobes that clear the recursion modules and handles the pipeline warm-up.

---
 rtl/batch_scheduler_pkg.sv | 25 ++
 rtl/batch_scheduler_section_ring.sv | 35 +++
 rtl/batch_scheduler.sv | 89 ++++++++
 tb/tb_batch_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/batch_scheduler_pkg.sv
// Shared types and helpers for the batch filter RAM scheduler.
// Section bases come from a constant mux, so no multiplier is needed.
package batch_pkg;

  localparam int NSEC   = 3;
  localparam int BASE_W = 16;

  typedef enum logic [1:0] {
    FILL0,
    FILL1,
    RUN
  } sched_state_e;

  // Returns sec*depth. The caller truncates the result to its own address width.
  function automatic logic [BASE_W-1:0] sec_base(input logic [1:0] sec, input int depth);
    logic [BASE_W-1:0] base;
    case (sec)
      2'd1:    base = BASE_W'(depth);
      2'd2:    base = BASE_W'(2 * depth);
      default: base = '0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/batch_scheduler_section_ring.sv
// Mod-3 counter that selects the RAM section being written.
// The two read sections are the write section minus one and minus two.
module section_ring
  import batch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [1:0] wsec,
  output logic [1:0] rsec,
  output logic [1:0] fsec
);

  logic [1:0] wsec_q, wsec_d;

  always_comb begin
    wsec_d = wsec_q;
    if (advance) begin
      wsec_d = (wsec_q == 2'(NSEC - 1)) ? 2'd0 : wsec_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wsec_q <= 2'd0;
    end else begin
      wsec_q <= wsec_d;
    end
  end

  assign wsec = wsec_q;
  assign rsec = (wsec_q == 2'd0) ? 2'd2 : wsec_q - 2'd1;
  assign fsec = (wsec_q == 2'd2) ? 2'd0 : wsec_q + 2'd1;

endmodule

// File: rtl/batch_scheduler.sv
// Generates the write, backward-read and forward-read addresses for the triple-buffered sample RAM.
// It also produces the batch strobes and handles pipeline warm-up.
module batch_scheduler
  import batch_pkg::*;
#(
  parameter  int depth = 64,
  localparam int AW    = $clog2(3 * depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          rev_en,
  output logic [AW-1:0] rev_addr,
  output logic          rev_first,
  output logic          fwd_en,
  output logic [AW-1:0] fwd_addr,
  output logic          fwd_first,
  output logic          batch_done,
  output logic          out_valid
);

  localparam int CW = $clog2(depth);

  logic [CW-1:0] cnt_q, cnt_d;
  sched_state_e  state_q, state_d;
  logic          advance;
  logic          last;
  logic [1:0]    wsec, rsec, fsec;
  logic [AW-1:0] wr_raw, rev_raw, fwd_raw;

  section_ring u_ring (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .wsec    (wsec),
    .rsec    (rsec),
    .fsec    (fsec)
  );

  assign last = (cnt_q == CW'(depth - 1));

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    advance = 1'b0;
    if (in_valid) begin
      if (last) begin
        cnt_d   = '0;
        advance = 1'b1;
        case (state_q)
          FILL0:   state_d = FILL1;
          FILL1:   state_d = RUN;
          default: state_d = RUN;
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      state_q <= FILL0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign wr_raw  = AW'(sec_base(wsec, depth)) + AW'(cnt_q);
  assign rev_raw = AW'(sec_base(rsec, depth)) + (AW'(depth - 1) - AW'(cnt_q));
  assign fwd_raw = AW'(sec_base(fsec, depth)) + AW'(cnt_q);

  // Everything is forced low while reset is held, including the address buses.
  assign wr_addr    = {AW{rst}} & wr_raw;
  assign rev_addr   = {AW{rst}} & rev_raw;
  assign fwd_addr   = {AW{rst}} & fwd_raw;
  assign wr_en      = rst & in_valid;
  assign rev_en     = rst & in_valid & (state_q != FILL0);
  assign fwd_en     = rst & in_valid & (state_q == RUN);
  assign rev_first  = rev_en & (cnt_q == '0);
  assign fwd_first  = fwd_en & (cnt_q == '0);
  assign batch_done = rst & in_valid & last;
  assign out_valid  = fwd_en;

endmodule

// File: tb/tb_batch_scheduler.sv
// Bench for batch_scheduler at depth=4: a sample-count model, directed literal vectors
// and a read-once scoreboard under random stalls.
module tb_batch_scheduler;

  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int NADDR = 3 * DEPTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          wr_en, rev_en, rev_first, fwd_en, fwd_first, batch_done, out_valid;
  logic [AW-1:0] wr_addr, rev_addr, fwd_addr;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  bit sb_on  = 1'b0;
  int wr_seen [NADDR];
  int rev_cnt [NADDR];
  int fwd_cnt [NADDR];

  batch_scheduler #(.depth(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rev_en     (rev_en),
    .rev_addr   (rev_addr),
    .rev_first  (rev_first),
    .fwd_en     (fwd_en),
    .fwd_addr   (fwd_addr),
    .fwd_first  (fwd_first),
    .batch_done (batch_done),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic v);
    @(posedge clk);
    #1 in_valid = v;
  endtask

  task automatic clear_scoreboard();
    for (int a = 0; a < NADDR; a++) begin
      wr_seen[a] = 0;
      rev_cnt[a] = 0;
      fwd_cnt[a] = 0;
    end
  endtask

  // Model state is the number of accepted samples since reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) n_acc <= 0;
    else if (in_valid) n_acc <= n_acc + 1;
  end

  // Expected outputs follow from the batch number b and the in-batch position k.
  always @(negedge clk) begin
    int b, k, e_wr, e_rev, e_fwd;
    bit v, e_ren, e_fen;
    b     = n_acc / DEPTH;
    k     = n_acc % DEPTH;
    v     = rst && in_valid;
    e_ren = v && (b >= 1);
    e_fen = v && (b >= 2);
    e_wr  = rst ? ((b % 3) * DEPTH + k) : 0;
    e_rev = rst ? (((b + 2) % 3) * DEPTH + (DEPTH - 1 - k)) : 0;
    e_fwd = rst ? (((b + 1) % 3) * DEPTH + k) : 0;
    check_output("m_wr_en",      int'(wr_en),      int'(v));
    check_output("m_wr_addr",    int'(wr_addr),    e_wr);
    check_output("m_rev_en",     int'(rev_en),     int'(e_ren));
    check_output("m_rev_addr",   int'(rev_addr),   e_rev);
    check_output("m_rev_first",  int'(rev_first),  int'(e_ren && k == 0));
    check_output("m_fwd_en",     int'(fwd_en),     int'(e_fen));
    check_output("m_fwd_addr",   int'(fwd_addr),   e_fwd);
    check_output("m_fwd_first",  int'(fwd_first),  int'(e_fen && k == 0));
    check_output("m_batch_done", int'(batch_done), int'(v && k == DEPTH - 1));
    check_output("m_out_valid",  int'(out_valid),  int'(e_fen));
  end

  // Every written word must be read backward once, then forward once, before it is overwritten.
  always @(negedge clk) begin
    if (sb_on && rst && in_valid) begin
      if (rev_en) begin
        check_output("sb_sec_wr_rev", int'(wr_addr / DEPTH != rev_addr / DEPTH), 1);
        check_output("sb_rev_once", wr_seen[rev_addr] * 10 + rev_cnt[rev_addr], 10);
        rev_cnt[rev_addr]++;
      end
      if (fwd_en) begin
        check_output("sb_sec_wr_fwd", int'(wr_addr / DEPTH != fwd_addr / DEPTH), 1);
        check_output("sb_sec_rev_fwd", int'(rev_addr / DEPTH != fwd_addr / DEPTH), 1);
        check_output("sb_fwd_once", rev_cnt[fwd_addr] * 10 + fwd_cnt[fwd_addr], 10);
        fwd_cnt[fwd_addr]++;
      end
      if (wr_seen[wr_addr] != 0) begin
        check_output("sb_drained", rev_cnt[wr_addr] * 10 + fwd_cnt[wr_addr], 11);
      end
      wr_seen[wr_addr] = 1;
      rev_cnt[wr_addr] = 0;
      fwd_cnt[wr_addr] = 0;
    end
  end

  initial begin
    int exp_wr  [16];
    int exp_rev [16];
    int exp_fwd [16];
    int acc, cyc;
    exp_wr  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0, 1, 2, 3};
    exp_rev = '{0, 0, 0, 0, 3, 2, 1, 0, 7, 6, 5, 4, 11, 10, 9, 8};
    exp_fwd = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7};

    #2;
    check_output("rst_rev_addr", int'(rev_addr), 0);
    check_output("rst_fwd_addr", int'(fwd_addr), 0);
    check_output("rst_wr_en", int'(wr_en), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Warm-up through the first four batches.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1);
      @(negedge clk);
      check_output("d_wr_addr", int'(wr_addr), exp_wr[i]);
      check_output("d_rev_en", int'(rev_en), int'(i >= 4));
      if (i >= 4) check_output("d_rev_addr", int'(rev_addr), exp_rev[i]);
      check_output("d_rev_first", int'(rev_first), int'(i == 4 || i == 8 || i == 12));
      check_output("d_fwd_en", int'(fwd_en), int'(i >= 8));
      if (i >= 8) check_output("d_fwd_addr", int'(fwd_addr), exp_fwd[i]);
      check_output("d_fwd_first", int'(fwd_first), int'(i == 8 || i == 12));
      check_output("d_batch_done", int'(batch_done), int'(i % 4 == 3));
    end

    // Stall for two cycles in RUN.
    apply_stimulus(1'b1);
    @(negedge clk);
    check_output("t_wr_addr0", int'(wr_addr), 4);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b0);
      @(negedge clk);
      check_output("t_wr_en", int'(wr_en), 0);
      check_output("t_rev_en", int'(rev_en), 0);
      check_output("t_out_valid", int'(out_valid), 0);
      check_output("t_wr_addr", int'(wr_addr), 5);
      check_output("t_rev_addr", int'(rev_addr), 2);
      check_output("t_fwd_addr", int'(fwd_addr), 9);
    end
    apply_stimulus(1'b1);
    @(negedge clk);
    check_output("t_resume_wr", int'(wr_addr), 5);
    check_output("t_resume_rev_en", int'(rev_en), 1);

    // Asynchronous reset between edges at cnt=2 in RUN.
    apply_stimulus(1'b1);
    #2 rst = 1'b0;
    #1;
    check_output("r_wr_en", int'(wr_en), 0);
    check_output("r_fwd_en", int'(fwd_en), 0);
    check_output("r_rev_addr", int'(rev_addr), 0);
    check_output("r_fwd_addr", int'(fwd_addr), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_output("r_restart_wr", int'(wr_addr), 0);
    check_output("r_restart_rev_en", int'(rev_en), 0);

    // Fresh start for the random-stall scoreboard run.
    apply_stimulus(1'b0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    clear_scoreboard();
    sb_on = 1'b1;
    acc = 0;
    cyc = 0;
    while (acc < 100 * DEPTH && cyc < 5000) begin
      apply_stimulus(1'($urandom_range(0, 1)));
      if (in_valid) acc++;
      cyc++;
    end
    check_output("rnd_budget", int'(acc >= 100 * DEPTH), 1);
    apply_stimulus(1'b0);
    @(negedge clk);
    sb_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
